// File: rtl/iir_ff_serial_if.sv
// Sample handshake bundle for the IIR feed-forward stage: input sample valid/ready
// plus the rounded output sample and its one-cycle valid strobe.
interface iir_ff_serial_if #(
    parameter int PRECISION = 24
);
    logic                        x_valid;
    logic                        x_ready;
    logic signed [PRECISION-1:0] x;
    logic                        y_valid;
    logic signed [PRECISION-1:0] y;

    modport master (
        output x_valid,
        output x,
        input  x_ready,
        input  y_valid,
        input  y
    );

    modport slave (
        input  x_valid,
        input  x,
        output x_ready,
        output y_valid,
        output y
    );
endinterface

// File: rtl/iir_ff_serial.sv
// Feed-forward (b-coefficient) IIR stage: y[n] = sum b[k]*x[n-k] with one shared multiplier.
// Define IIR_FF_SAT_EN to clamp the rounded result instead of wrapping it.
module iir_ff_serial #(
    parameter int N           = 2,
    parameter int PRECISION   = 24,
    parameter int COEFF_WIDTH = 16,
    parameter int COEFF_FRAC  = 14
) (
    input  logic                         clk,
    input  logic                         rst_n,
    iir_ff_serial_if.slave               s_if,
    input  logic [COEFF_WIDTH*(N+1)-1:0] packed_b_coeffs,
    output logic                         busy
);
    localparam int KW = $clog2(N + 1);
    localparam int PW = PRECISION + COEFF_WIDTH;
    localparam int AW = PW + $clog2(N + 1);
    localparam int SW = AW - COEFF_FRAC;

    localparam logic [AW-1:0]        RND_BIAS = AW'(1) << (COEFF_FRAC - 1);
    localparam logic [KW-1:0]        K_LAST   = KW'(N);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                        state_q, state_d;
    logic signed [PRECISION-1:0]   dly_q [N+1];
    logic signed [PRECISION-1:0]   dly_d [N+1];
    logic signed [COEFF_WIDTH-1:0] b_q   [N+1];
    logic signed [COEFF_WIDTH-1:0] b_d   [N+1];
    logic signed [COEFF_WIDTH-1:0] b_in  [N+1];
    logic signed [AW-1:0]          acc_q, acc_d;
    logic [KW-1:0]                 k_q, k_d;
    logic signed [PRECISION-1:0]   y_q, y_d;
    logic                          y_valid_q, y_valid_d;
    logic                          x_ready_q, x_ready_d;
    logic                          busy_q, busy_d;

    logic                          accept;
    logic signed [PW-1:0]          prod;
    logic signed [AW-1:0]          acc_sum;
    logic signed [AW-1:0]          acc_rnd;
    logic signed [SW-1:0]          acc_shr;
    logic signed [PRECISION-1:0]   y_res;
    logic                          unused_bits;

    generate
        for (genvar gi = 0; gi <= N; gi++) begin : g_coeff
            assign b_in[gi] = packed_b_coeffs[COEFF_WIDTH*gi +: COEFF_WIDTH];
        end
    endgenerate

    // Shared MAC datapath; the final tap's sum is rounded in the same cycle so y
    // can be registered on the edge that enters OUT.
    assign prod    = PW'(dly_q[k_q]) * PW'(b_q[k_q]);
    assign acc_sum = acc_q + AW'(prod);
    assign acc_rnd = acc_sum + $signed(RND_BIAS);
    assign acc_shr = acc_rnd[AW-1:COEFF_FRAC];

`ifdef IIR_FF_SAT_EN
    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-PRECISION+1){1'b0}}, {(PRECISION-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-PRECISION+1){1'b1}}, {(PRECISION-1){1'b0}}};

    always_comb begin
        if (acc_shr > SAT_MAX) begin
            y_res = SAT_MAX[PRECISION-1:0];
        end else if (acc_shr < SAT_MIN) begin
            y_res = SAT_MIN[PRECISION-1:0];
        end else begin
            y_res = acc_shr[PRECISION-1:0];
        end
    end

    assign unused_bits = ^acc_rnd[COEFF_FRAC-1:0];
`else
    assign y_res       = acc_shr[PRECISION-1:0];
    assign unused_bits = ^{acc_rnd[COEFF_FRAC-1:0], acc_shr[SW-1:PRECISION]};
`endif

    assign accept = s_if.x_valid && x_ready_q;

    always_comb begin
        state_d   = state_q;
        dly_d     = dly_q;
        b_d       = b_q;
        acc_d     = acc_q;
        k_d       = k_q;
        y_d       = y_q;
        y_valid_d = 1'b0;
        x_ready_d = x_ready_q;
        busy_d    = busy_q;

        case (state_q)
            IDLE, OUT: begin
                if (accept) begin
                    dly_d[0] = s_if.x;
                    for (int i = 1; i <= N; i++) begin
                        dly_d[i] = dly_q[i-1];
                    end
                    b_d       = b_in;
                    acc_d     = '0;
                    k_d       = '0;
                    x_ready_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = MAC;
                end else begin
                    x_ready_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end
            MAC: begin
                acc_d = acc_sum;
                k_d   = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    k_d       = '0;
                    y_d       = y_res;
                    y_valid_d = 1'b1;
                    x_ready_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = OUT;
                end
            end
            default: begin
                x_ready_d = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            for (int i = 0; i <= N; i++) begin
                dly_q[i] <= '0;
                b_q[i]   <= '0;
            end
            acc_q     <= '0;
            k_q       <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            x_ready_q <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dly_q     <= dly_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            k_q       <= k_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            x_ready_q <= x_ready_d;
            busy_q    <= busy_d;
        end
    end

    assign s_if.x_ready = x_ready_q;
    assign s_if.y_valid = y_valid_q;
    assign s_if.y       = y_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_iir_ff_serial.sv
// Directed bench for iir_ff_serial (N=2, 24-bit samples, Q2.14 coefficients).
module tb_iir_ff_serial;
    localparam int N  = 2;
    localparam int P  = 24;
    localparam int CW = 16;
    localparam int CF = 14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [CW*(N+1)-1:0] coeffs;
    logic busy;

    always #5 clk = ~clk;

    iir_ff_serial_if #(.PRECISION(P)) bus ();

    iir_ff_serial #(
        .N(N), .PRECISION(P), .COEFF_WIDTH(CW), .COEFF_FRAC(CF)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_if            (bus),
        .packed_b_coeffs (coeffs),
        .busy            (busy)
    );

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int yv_cnt = 0;
    int yq[$];
    int ycyc[$];
    int acc_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Everything is observed mid-cycle; inputs only change 1ns after a rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.x_valid && bus.x_ready) begin
            acc_cyc.push_back(cyc);
            acc_cnt++;
            $display("[TB] cycle %0d accept x=%0d", cyc, bus.x);
        end
        if (bus.y_valid) begin
            yq.push_back(int'(bus.y));
            ycyc.push_back(cyc);
            yv_cnt++;
            $display("[TB] cycle %0d output y=%0d", cyc, bus.y);
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_b(input int b0, input int b1, input int b2);
        coeffs = {CW'(b2), CW'(b1), CW'(b0)};
    endtask

    // Present one sample and hold it until accepted; returns 1ns after the accepting edge.
    task automatic send(input int v);
        bit ok;
        ok = 1'b0;
        bus.x       = P'(v);
        bus.x_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.x_ready;
            @(posedge clk);
            #1;
        end
        bus.x_valid = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic wait_y(input int n, input string tag);
        int i;
        i = 0;
        while (yq.size() < n && i < 200) begin
            @(posedge clk);
            i++;
        end
        repeat (8) @(posedge clk);
        #1;
        check(tag, yq.size(), n);
    endtask

    function automatic int pop_y();
        if (yq.size() == 0) return -99999999;
        return yq.pop_front();
    endfunction

    task automatic clear_logs();
        yq.delete();
        ycyc.delete();
        acc_cyc.delete();
    endtask

    task automatic check_impulse(input string tag);
        check({tag, "_y0"}, pop_y(), 500);
        check({tag, "_y1"}, pop_y(), 250);
        check({tag, "_y2"}, pop_y(), 250);
        check({tag, "_y3"}, pop_y(), 0);
    endtask

    int base;
    int lat;
    int gap1;
    int gap2;

    initial begin
        bus.x_valid = 1'b0;
        bus.x       = '0;
        coeffs      = '0;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_y", bus.y, 0);
        check("rst_y_valid", bus.y_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_x_ready", bus.x_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Impulse, driven back-to-back so every later sample is taken in OUT
        set_b(8192, 4096, 4096);
        clear_logs();
        send(1000);
        send(0);
        send(0);
        send(0);
        wait_y(4, "impulse_count");
        lat  = (ycyc.size() > 0 && acc_cyc.size() > 0) ? ycyc[0] - acc_cyc[0] : -1;
        gap1 = (acc_cyc.size() > 1) ? acc_cyc[1] - acc_cyc[0] : -1;
        gap2 = (acc_cyc.size() > 2) ? acc_cyc[2] - acc_cyc[1] : -1;
        check("latency", lat, N + 2);
        check("no_bubble_1", gap1, N + 2);
        check("no_bubble_2", gap2, N + 2);
        check_impulse("impulse");

        // x_ready low for exactly N+1 cycles, then a single y_valid pulse
        clear_logs();
        send(0);
        for (int i = 0; i < N + 1; i++) begin
            @(negedge clk);
            check("mac_x_ready", bus.x_ready, 0);
            check("mac_busy", busy, 1);
        end
        @(negedge clk);
        check("out_x_ready", bus.x_ready, 1);
        check("out_y_valid", bus.y_valid, 1);
        @(negedge clk);
        check("idle_y_valid", bus.y_valid, 0);
        check("idle_busy", busy, 0);
        @(posedge clk);
        #1;
        clear_logs();

        // x_valid held for 10 cycles: three acceptances at N+2 spacing
        set_b(16384, 0, 0);
        base        = acc_cnt;
        bus.x       = P'(100);
        bus.x_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bus.x_valid = 1'b0;
        wait_y(3, "held_count");
        check("held_accepts", acc_cnt - base, 3);
        for (int i = 0; i < 3; i++) check("held_y", pop_y(), 100);

        // Round half up at the LSB boundary
        clear_logs();
        set_b(1, 0, 0);
        send(8192);
        send(-8192);
        wait_y(2, "round_count");
        check("round_pos", pop_y(), 1);
        check("round_neg", pop_y(), 0);

        // Full-scale input with near-unity taps overflows the output width
        clear_logs();
        set_b(16383, 16383, 16383);
        send(8388607);
        send(8388607);
        send(8388607);
        wait_y(3, "ovf_count");
        void'(pop_y());
        void'(pop_y());
`ifdef IIR_FF_SAT_EN
        check("ovf_final", pop_y(), 8388607);
`else
        check("ovf_final", pop_y(), 8387069);
`endif

        // Reset on the second MAC cycle aborts the sample
        clear_logs();
        set_b(8192, 4096, 4096);
        base = yv_cnt;
        send(1000);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_y", bus.y, 0);
        check("abort_y_valid", bus.y_valid, 0);
        check("abort_x_ready", bus.x_ready, 1);
        check("abort_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_pulse", yv_cnt - base, 0);
        check("abort_ready_after", bus.x_ready, 1);

        clear_logs();
        send(1000);
        send(0);
        send(0);
        send(0);
        wait_y(4, "post_rst_count");
        check_impulse("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
